sync_edge_filter: RTL and testbench
===================================

Name: sync_edge_filter

Overview:
- Parametrised successor of the two-flop input synchroniser: N independent channels, configurable synchroniser depth, per-channel glitch filter, and registered rise/fall edge pulses.
- Sits between the registered asynchronous inputs (pads or foreign-clock signals) and the core logic.
- Downstream logic consumes clean, stable levels and single-cycle edge strobes.

Parameters:
- N, 8, number of independent channels (>=1).
- STAGES, 2, synchroniser flops per channel (>=2; elaboration error otherwise).
- FILT_CYCLES, 4, consecutive enabled cycles a new synchronised level must persist before data_out updates (>=1; elaboration error otherwise).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  high when design enabled; all state advances only when ena=1.
- data_in  input  N  asynchronous channel inputs.
- sync_out  output  N  raw output of last synchroniser stage, unfiltered.
- data_out  output  N  filtered, stable level.
- rise  output  N  one-cycle pulse per channel on data_out 0->1.
- fall  output  N  one-cycle pulse per channel on data_out 1->0.
- any_change  output  1  OR-reduction of rise|fall, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, filter counters, data_out, rise, fall, any_change -> 0. Reset mid-filter discards the count.
- Synchroniser:
  - Per channel, a shift chain of STAGES flops; stage0 <= data_in, stage k <= stage k-1.
  - Chain advances only when ena=1, otherwise it holds.
  - sync_out = last stage.
- Filter, per channel i, counter cnt_i of width clog2(FILT_CYCLES+1):
  - sync_out[i]==data_out[i]: cnt_i <= 0.
  - Differs and cnt_i < FILT_CYCLES-1: cnt_i <= cnt_i+1.
  - Differs and cnt_i == FILT_CYCLES-1: data_out[i] <= sync_out[i]; cnt_i <= 0.
  - A pulse shorter than FILT_CYCLES enabled cycles never reaches data_out. The counter restarts from 0 on any return to the current level.
  - The counter never exceeds FILT_CYCLES-1; there is no wrap.
- Latency, ena held high: data_in change set up before edge 1 appears on sync_out after edge STAGES and on data_out after edge STAGES+FILT_CYCLES.
- Edges:
  - rise[i]/fall[i] are registered in the same clock edge that updates data_out[i], and are high for exactly one cycle.
  - any_change is registered alongside them.
- ena=0:
  - Chain, counters and data_out hold.
  - rise, fall and any_change are forced to 0 at the next edge, so pulses never stretch.
- Simultaneous events:
  - Channels are fully independent; several channels may pulse in the same cycle.
  - rise[i] and fall[i] are never both high.
- A channel held at 1 through reset produces a rise pulse one full latency after release. This is intended and not masked.

Optional Feature:
- Macro SYNC_EDGE_FILTER_EN.
- Defined: glitch filter as above.
- Undefined:
  - No counters.
  - data_out[i] <= sync_out[i] every enabled cycle, with latency STAGES+1 (same as FILT_CYCLES=1).
  - Edge and ena-gating rules are unchanged.
  - FILT_CYCLES is ignored.

Decomposition:
- Shared package sync_pkg:
  - constants SYNC_MIN_STAGES=2 and FILT_MIN_CYCLES=1;
  - function cnt_width(FILT_CYCLES) returning clog2(FILT_CYCLES+1);
  - typedef of the per-channel filter state.
- Sub-module sync_bit_filter: one channel (chain + filter + edge regs), instantiated N times in a generate loop.
- The top level builds only the any_change reduction register.

Test Plan (N=8, STAGES=2, FILT_CYCLES=4, macro defined unless noted):
- rst_n=0 with data_in=0xFF, then release with ena=1 -> all outputs 0 during reset; sync_out=0xFF after edge 2; data_out=0xFF after edge 6; rise=0xFF and any_change=1 for exactly one cycle; fall=0.
- From data_out=0x00, data_in[0]=1 for 3 enabled cycles then 0 -> data_out, rise and any_change stay 0. Repeat with 4 cycles -> data_out=0x01, one rise[0] pulse.
- data_out=0xFF, data_in=0x0F -> after 6 edges data_out=0x0F, fall=0xF0 for one cycle, rise=0.
- Hold ena=0 for 5 cycles mid-filter (cnt=2) -> data_out unchanged, counters hold; re-enable -> update after 2 more edges. ena=0 in the cycle after an update -> pulses drop to 0.
- Assert rst_n mid-filter (cnt=3) -> all outputs 0 immediately, no edge pulse emitted.
- Macro undefined: 1-cycle data_in[3] pulse aligned to clock -> appears on data_out[3] for one cycle at latency 3, with matching rise and fall pulses.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants, types and helpers for the sync_edge_filter slice.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int FILT_MIN_CYCLES = 1;

  // Registered per-channel filter outputs: stable level plus its edge strobes.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } filt_state_t;

  function automatic int cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_edge_filter_if.sv
// Channel bundle between the asynchronous inputs and the core for sync_edge_filter.
interface sync_edge_filter_if #(
  parameter int N = 8
);
  logic         ena;
  logic [N-1:0] data_in;
  logic [N-1:0] sync_out;
  logic [N-1:0] data_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_change;

  modport master (
    output ena, data_in,
    input  sync_out, data_out, rise, fall, any_change
  );

  modport slave (
    input  ena, data_in,
    output sync_out, data_out, rise, fall, any_change
  );
endinterface

// File: rtl/sync_bit_filter.sv
// One channel: STAGES-deep synchroniser, glitch filter and registered edge strobes.
// Glitch filter enabled by `define SYNC_EDGE_FILTER_EN; otherwise data_out tracks sync_out.
module sync_bit_filter
  import sync_pkg::*;
#(
  parameter int STAGES      = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic sync_q,
  output logic level,
  output logic rise,
  output logic fall,
  output logic chg_nxt
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_bit_filter: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILT_CYCLES < FILT_MIN_CYCLES) begin : g_bad_filt
    $error("sync_bit_filter: FILT_CYCLES must be >= %0d", FILT_MIN_CYCLES);
  end

  logic [STAGES-1:0] chain_p0;
  filt_state_t       filt_p1;
  filt_state_t       filt_nxt;

  // Stage 0: synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_p0 <= '0;
    end else if (ena) begin
      chain_p0 <= {chain_p0[STAGES-2:0], d};
    end
  end

  assign sync_q = chain_p0[STAGES-1];

  // Stage 1: level filter and edge strobes
`ifdef SYNC_EDGE_FILTER_EN
  localparam int              CW       = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [CW-1:0] cnt_p1;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    filt_nxt       = filt_p1;
    filt_nxt.rise  = 1'b0;
    filt_nxt.fall  = 1'b0;
    cnt_nxt        = cnt_p1;
    if (ena) begin
      if (sync_q == filt_p1.level) begin
        cnt_nxt = '0;
      end else if (cnt_p1 == CNT_LAST) begin
        filt_nxt.level = sync_q;
        filt_nxt.rise  = sync_q;
        filt_nxt.fall  = ~sync_q;
        cnt_nxt        = '0;
      end else begin
        cnt_nxt = cnt_p1 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_nxt;
    end
  end
`else
  always_comb begin
    filt_nxt      = filt_p1;
    filt_nxt.rise = 1'b0;
    filt_nxt.fall = 1'b0;
    if (ena) begin
      filt_nxt.level = sync_q;
      filt_nxt.rise  = sync_q & ~filt_p1.level;
      filt_nxt.fall  = ~sync_q & filt_p1.level;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_p1 <= '0;
    end else begin
      filt_p1 <= filt_nxt;
    end
  end

  assign level   = filt_p1.level;
  assign rise    = filt_p1.rise;
  assign fall    = filt_p1.fall;
  // Exposed so the top can register any_change on the same edge as the strobes.
  assign chg_nxt = filt_nxt.rise | filt_nxt.fall;

endmodule

// File: rtl/sync_edge_filter.sv
// N-channel synchroniser with per-channel glitch filter and rise/fall strobes.
// Glitch filter enabled by `define SYNC_EDGE_FILTER_EN.
module sync_edge_filter
  import sync_pkg::*;
#(
  parameter int N           = 8,
  parameter int STAGES      = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_edge_filter_if.slave bus
);

  logic [N-1:0] sync_v;
  logic [N-1:0] level_v;
  logic [N-1:0] rise_v;
  logic [N-1:0] fall_v;
  logic [N-1:0] chg_nxt;
  logic         any_p1;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sync_bit_filter #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (bus.ena),
      .d       (bus.data_in[i]),
      .sync_q  (sync_v[i]),
      .level   (level_v[i]),
      .rise    (rise_v[i]),
      .fall    (fall_v[i]),
      .chg_nxt (chg_nxt[i])
    );
  end

  // Stage 1: any_change, aligned with the per-channel strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_p1 <= 1'b0;
    end else begin
      any_p1 <= |chg_nxt;
    end
  end

  assign bus.sync_out   = sync_v;
  assign bus.data_out   = level_v;
  assign bus.rise       = rise_v;
  assign bus.fall       = fall_v;
  assign bus.any_change = any_p1;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed + random bench for sync_edge_filter with a queue scoreboard fed by a sample-history model.
module tb_sync_edge_filter;
  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int FILT   = 4;
`ifdef SYNC_EDGE_FILTER_EN
  localparam int FE = FILT;
`else
  localparam int FE = 1;
`endif
  localparam int LAT = STAGES + FE;

  typedef struct packed {
    logic [N-1:0] s;
    logic [N-1:0] d;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic         a;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [N-1:0] din = '0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: chain of enabled samples and history of the last FE synchronised samples.
  logic [N-1:0] m_chain [STAGES];
  logic [N-1:0] hist [$];
  logic [N-1:0] m_level, m_rise, m_fall;
  logic         m_any;
  exp_t         sb [$];

  sync_edge_filter_if #(.N(N)) bus ();
  assign bus.ena     = ena;
  assign bus.data_in = din;

  sync_edge_filter #(
    .N           (N),
    .STAGES      (STAGES),
    .FILT_CYCLES (FILT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) m_chain[k] = '0;
    hist.delete();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_any   = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, nl;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) begin
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
      return;
    end
    s = m_chain[STAGES-1];
    for (int k = STAGES - 1; k > 0; k--) m_chain[k] = m_chain[k-1];
    m_chain[0] = din;
    hist.push_back(s);
    if (hist.size() > FE) void'(hist.pop_front());
    nl = m_level;
    if (hist.size() == FE) begin
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) nl[i] = ~m_level[i];
      end
    end
    m_rise  = nl & ~m_level;
    m_fall  = ~nl & m_level;
    m_any   = |(m_rise | m_fall);
    m_level = nl;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    e.s = m_chain[STAGES-1];
    e.d = m_level;
    e.r = m_rise;
    e.f = m_fall;
    e.a = m_any;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_sync_out", 32'(bus.sync_out), 32'(e.s));
      chk("sb_data_out", 32'(bus.data_out), 32'(e.d));
      chk("sb_rise", 32'(bus.rise), 32'(e.r));
      chk("sb_fall", 32'(bus.fall), 32'(e.f));
      chk("sb_any_change", 32'(bus.any_change), 32'(e.a));
    end
  endtask

  initial begin
    // Reset held with all inputs high
    rst_n = 1'b0;
    ena   = 1'b1;
    din   = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sync_out", 32'(bus.sync_out), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_rise", 32'(bus.rise), 32'h0);
    chk("rst_any", 32'(bus.any_change), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("sync_before_lat", 32'(bus.sync_out), 32'h00);
    tick();
    chk("sync_lat", 32'(bus.sync_out), 32'hFF);
    repeat (LAT - 2) tick();
    chk("rel_data_out", 32'(bus.data_out), 32'hFF);
    chk("rel_rise", 32'(bus.rise), 32'hFF);
    chk("rel_fall", 32'(bus.fall), 32'h00);
    chk("rel_any", 32'(bus.any_change), 32'h1);
    tick();
    chk("rel_rise_drop", 32'(bus.rise), 32'h00);
    chk("rel_any_drop", 32'(bus.any_change), 32'h0);

    // Back to all-zero
    din = 8'h00;
    repeat (LAT) tick();
    chk("fall_all_data", 32'(bus.data_out), 32'h00);
    chk("fall_all", 32'(bus.fall), 32'hFF);
    tick();

`ifdef SYNC_EDGE_FILTER_EN
    // Three-cycle glitch is rejected, four-cycle pulse passes
    din = 8'h01;
    repeat (3) tick();
    din = 8'h00;
    repeat (LAT + 2) tick();
    chk("glitch3_data", 32'(bus.data_out), 32'h00);
    din = 8'h01;
    repeat (4) tick();
    din = 8'h00;
    repeat (2) tick();
    chk("pulse4_data", 32'(bus.data_out), 32'h01);
    chk("pulse4_rise", 32'(bus.rise), 32'h01);
    repeat (LAT + 2) tick();
`endif

    // Upper nibble falls
    din = 8'hFF;
    repeat (LAT + 1) tick();
    din = 8'h0F;
    repeat (LAT - 1) tick();
    chk("nib_hold", 32'(bus.data_out), 32'hFF);
    tick();
    chk("nib_data", 32'(bus.data_out), 32'h0F);
    chk("nib_fall", 32'(bus.fall), 32'hF0);
    chk("nib_rise", 32'(bus.rise), 32'h00);
    tick();
    chk("nib_fall_drop", 32'(bus.fall), 32'h00);

    // ena low while a change is partly counted
    din = 8'hFF;
`ifdef SYNC_EDGE_FILTER_EN
    repeat (STAGES + 2) tick();
    ena = 1'b0;
    repeat (5) tick();
    chk("ena_hold_data", 32'(bus.data_out), 32'h0F);
    ena = 1'b1;
    tick();
    chk("ena_resume1", 32'(bus.data_out), 32'h0F);
    tick();
    chk("ena_resume2", 32'(bus.data_out), 32'hFF);
    chk("ena_resume_rise", 32'(bus.rise), 32'hF0);
`else
    repeat (LAT) tick();
`endif
    din = 8'h00;
    repeat (LAT) tick();
    chk("upd_fall", 32'(bus.fall), 32'hFF);
    chk("upd_any", 32'(bus.any_change), 32'h1);
    ena = 1'b0;
    tick();
    chk("gate_fall", 32'(bus.fall), 32'h00);
    chk("gate_any", 32'(bus.any_change), 32'h0);
    chk("gate_data", 32'(bus.data_out), 32'h00);
    ena = 1'b1;

    // Reset one edge before an update
    din = 8'hFF;
    repeat (LAT - 1) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(bus.data_out), 32'h00);
    chk("midrst_sync", 32'(bus.sync_out), 32'h00);
    chk("midrst_rise", 32'(bus.rise), 32'h00);
    chk("midrst_any", 32'(bus.any_change), 32'h0);
    model_reset();
    sb.delete();
    tick();
    chk("midrst_norise", 32'(bus.rise), 32'h00);
    rst_n = 1'b1;
    repeat (LAT + 2) tick();

    // Single-cycle pulse on channel 3
    din = 8'h00;
    repeat (LAT + 2) tick();
    din = 8'h08;
    tick();
    din = 8'h00;
`ifdef SYNC_EDGE_FILTER_EN
    repeat (LAT + 2) tick();
    chk("p1_filtered", 32'(bus.data_out), 32'h00);
`else
    repeat (2) tick();
    chk("p1_data", 32'(bus.data_out), 32'h08);
    chk("p1_rise", 32'(bus.rise), 32'h08);
    tick();
    chk("p1_data_back", 32'(bus.data_out), 32'h00);
    chk("p1_fall", 32'(bus.fall), 32'h08);
`endif

    // Random phase, checked by the scoreboard
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) din = N'($urandom);
      ena = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
